// File: rtl/mips_io_pkg.sv
// Shared definitions for memory-mapped I/O blocks on the MIPS_System data bus.
package mips_io_pkg;

  // Byte offsets of the timer registers from the block base address.
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_RELOAD = 4'hC;

  // CTRL register bit positions.
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0010;

  typedef enum logic {
    StIdle,
    StRun
  } timer_state_e;

endpackage

// File: rtl/mips_timer_if.sv
// Data-bus slice seen by a memory-mapped peripheral: select, strobe, address, data, interrupt.
interface mips_timer_if;
  logic        cs;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output cs,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  cs,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every PRESCALE cycles while enabled.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: restart on clear, hold at zero while disabled, wrap after the tick.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || !en || tick) begin
      cnt_d = '0;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a level irq.
module mips_timer
  import mips_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned PRESCALE  = 50,
  parameter int unsigned CNT_W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  mips_timer_if.slave  bus
);

  timer_state_e     state_q, state_d;
  logic             auto_q, auto_d;
  logic             irq_en_q, irq_en_d;
  logic             expired_q, expired_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;

  logic [31:0] off;
  logic [3:0]  reg_off;
  logic        hit;
  logic        wr_ctrl, wr_status, wr_count, wr_reload;
  logic        running, tick, expire, presc_clr;
  logic        unused_off;

  // Offset relative to the base so any word-aligned base decodes correctly.
  assign off        = bus.addr - BASE_ADDR;
  assign hit        = bus.cs && (off[31:4] == 28'h0);
  assign reg_off    = {off[3:2], 2'b00};
  assign unused_off = ^off[1:0];

  assign wr_ctrl   = hit && bus.we && (reg_off == OFF_CTRL);
  assign wr_status = hit && bus.we && (reg_off == OFF_STATUS);
  assign wr_count  = hit && bus.we && (reg_off == OFF_COUNT);
  assign wr_reload = hit && bus.we && (reg_off == OFF_RELOAD);

  assign running = (state_q == StRun);
  // Only an IDLE->RUN write restarts the prescaler; rewriting CTRL while running keeps phase.
  assign presc_clr = wr_ctrl && bus.wdata[CTRL_EN] && !running;
  assign expire    = tick && running && (count_q <= CNT_W'(1));

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (presc_clr),
    .en   (running),
    .tick (tick)
  );

  // Control FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Control FSM next state: a CTRL write overrides a simultaneous one-shot expiry.
  always_comb begin
    state_d = state_q;
    if (wr_ctrl) begin
      state_d = bus.wdata[CTRL_EN] ? StRun : StIdle;
    end else if (expire && !auto_q) begin
      state_d = StIdle;
    end
  end

  // Register-file and counter next-state logic.
  always_comb begin
    auto_d    = auto_q;
    irq_en_d  = irq_en_q;
    expired_d = expired_q;
    count_d   = count_q;
    reload_d  = reload_q;

    if (wr_ctrl) begin
      auto_d   = bus.wdata[CTRL_AUTO];
      irq_en_d = bus.wdata[CTRL_IRQ_EN];
    end

    // New expiry takes precedence over a same-cycle W1C.
    if (expire) begin
      expired_d = 1'b1;
    end else if (wr_status && bus.wdata[0]) begin
      expired_d = 1'b0;
    end

    // A CPU write to COUNT beats a same-cycle tick.
    if (wr_count) begin
      count_d = bus.wdata[CNT_W-1:0];
    end else if (tick && running) begin
      if (count_q > CNT_W'(1)) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = auto_q ? reload_q : '0;
      end
    end

    if (wr_reload) begin
      reload_d = bus.wdata[CNT_W-1:0];
    end
  end

  // Register-file state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      expired_q <= 1'b0;
      count_q   <= '0;
      reload_q  <= '0;
    end else begin
      auto_q    <= auto_d;
      irq_en_q  <= irq_en_d;
      expired_q <= expired_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
    end
  end

  // Combinational read mux; zero when not selected or outside the block.
  always_comb begin
    bus.rdata = 32'h0;
    if (hit) begin
      case (reg_off)
        OFF_CTRL:   bus.rdata = {29'h0, irq_en_q, auto_q, running};
        OFF_STATUS: bus.rdata = {31'h0, expired_q};
        OFF_COUNT:  bus.rdata = 32'(count_q);
        OFF_RELOAD: bus.rdata = 32'(reload_q);
        default:    bus.rdata = 32'h0;
      endcase
    end
  end

  assign bus.irq = expired_q && irq_en_q;

endmodule

// File: tb/tb_mips_timer.sv
// Scoreboard bench for mips_timer: the driver queues expected values, a negedge monitor checks.
module tb_mips_timer;
  import mips_io_pkg::*;

  localparam logic [31:0] BASE     = 32'hFFFF_0010;
  localparam logic [31:0] A_CTRL   = BASE + 32'(OFF_CTRL);
  localparam logic [31:0] A_STATUS = BASE + 32'(OFF_STATUS);
  localparam logic [31:0] A_COUNT  = BASE + 32'(OFF_COUNT);
  localparam logic [31:0] A_RELOAD = BASE + 32'(OFF_RELOAD);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_timer_if bus ();

  mips_timer #(
    .BASE_ADDR(BASE),
    .PRESCALE (4),
    .CNT_W    (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Scoreboard queues.
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          kind_q[$];  // 0: rdata, 1: irq
  bit          chk = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [31:0] m_exp, m_got;
  string       m_name;
  bit          m_kind;

  // Monitor: compare the presented output against the oldest expectation.
  always @(negedge clk) begin
    if (chk) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: got a check request, required a queued expectation");
      end else begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        m_kind = kind_q.pop_front();
        m_got  = m_kind ? {31'h0, bus.irq} : bus.rdata;
        if (m_got === m_exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", m_name, m_got, m_exp);
      end
    end
  end

  // One bus cycle; kind 0 = no check, 1 = check rdata, 2 = check irq.
  task automatic slot(input bit r, input bit c, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input int kind, input logic [31:0] e,
                      input string nm);
    @(posedge clk);
    #1;
    reset     = r;
    bus.cs    = c;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    if (kind != 0) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
      kind_q.push_back(kind == 2);
      chk = 1'b1;
    end else begin
      chk = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, "");
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    slot(1'b0, 1'b1, 1'b1, a, d, 0, 32'h0, "");
  endtask

  task automatic wr_nocs(input logic [31:0] a, input logic [31:0] d);
    slot(1'b0, 1'b0, 1'b1, a, d, 0, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    slot(1'b0, 1'b1, 1'b0, a, 32'h0, 1, e, nm);
  endtask

  task automatic rd_nocs(input logic [31:0] a, input logic [31:0] e, input string nm);
    slot(1'b0, 1'b0, 1'b0, a, 32'h0, 1, e, nm);
  endtask

  task automatic rd_rst(input logic [31:0] a, input logic [31:0] e, input string nm);
    slot(1'b1, 1'b1, 1'b0, a, 32'h0, 1, e, nm);
  endtask

  task automatic irq_is(input logic e, input string nm);
    slot(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2, {31'h0, e}, nm);
  endtask

  initial begin
    bus.cs    = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;

    // Reset state.
    rd_rst(A_CTRL, 32'h0, "reset_ctrl");
    rd(A_STATUS, 32'h0, "reset_status");
    rd(A_COUNT, 32'h0, "reset_count");
    rd(A_RELOAD, 32'h0, "reset_reload");
    irq_is(1'b0, "reset_irq");

    // One-shot: COUNT=3, PRESCALE=4 -> expiry visible 13 cycles after the CTRL write.
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h5);                     // cycle 0
    idle(11);                              // cycles 1..11
    irq_is(1'b0, "oneshot_irq_c12");       // 12
    rd(A_STATUS, 32'h1, "oneshot_exp_c13");// 13
    irq_is(1'b1, "oneshot_irq_c14");       // 14
    rd(A_CTRL, 32'h4, "oneshot_ctrl");     // en dropped, irq_en kept
    rd(A_COUNT, 32'h0, "oneshot_count");
    wr(A_STATUS, 32'h1);
    irq_is(1'b0, "oneshot_irq_cleared");
    rd(A_STATUS, 32'h0, "oneshot_status_cleared");

    // Auto-reload: RELOAD=2, COUNT=2 -> expiry every 8 cycles, ticks at 4, 8, 12, ...
    wr(A_RELOAD, 32'd2);
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h3);                     // cycle 0
    rd(A_COUNT, 32'd2, "auto_count_c1");   // 1
    idle(3);                               // 2..4
    rd(A_COUNT, 32'd1, "auto_count_c5");   // 5
    idle(2);                               // 6..7
    rd(A_STATUS, 32'h0, "auto_status_c8"); // 8
    rd(A_STATUS, 32'h1, "auto_status_c9"); // 9
    irq_is(1'b0, "auto_irq_masked");       // 10
    wr(A_STATUS, 32'h1);                   // 11
    rd(A_STATUS, 32'h0, "auto_w1c");       // 12
    rd(A_COUNT, 32'd1, "auto_count_c13");  // 13
    idle(2);                               // 14..15
    rd(A_STATUS, 32'h0, "auto_status_c16");// 16
    rd(A_STATUS, 32'h1, "auto_status_c17");// 17
    rd(A_COUNT, 32'd2, "auto_reloaded");   // 18
    wr(A_CTRL, 32'h7);                     // 19: enable irq, prescaler phase unchanged
    irq_is(1'b1, "auto_irq_en");           // 20
    idle(3);                               // 21..23
    wr(A_STATUS, 32'h1);                   // 24: W1C on an expiry cycle
    rd(A_STATUS, 32'h1, "w1c_race_set_wins"); // 25
    wr(A_STATUS, 32'h1);                   // 26
    irq_is(1'b0, "w1c_irq_drop");          // 27
    rd(A_STATUS, 32'h0, "w1c_cleared");    // 28
    wr(A_CTRL, 32'h0);                     // 29

    // COUNT write on a tick cycle wins.
    wr(A_COUNT, 32'd50);
    wr(A_CTRL, 32'h1);                     // cycle 0
    idle(3);                               // 1..3
    wr(A_COUNT, 32'd100);                  // 4: tick cycle
    rd(A_COUNT, 32'd100, "wrtick_write_wins"); // 5
    idle(2);                               // 6..7
    rd(A_COUNT, 32'd100, "wrtick_before_tick"); // 8
    rd(A_COUNT, 32'd99, "wrtick_next_tick");    // 9
    wr(A_CTRL, 32'h0);

    // Decode: out-of-block and unselected writes are ignored.
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    wr(BASE - 32'h4, 32'hFFFF_FFFF);
    wr_nocs(A_COUNT, 32'h1234);
    wr_nocs(A_CTRL, 32'h7);
    rd(A_COUNT, 32'd99, "decode_count");
    rd(A_CTRL, 32'h0, "decode_ctrl");
    rd(A_RELOAD, 32'd2, "decode_reload");
    rd(BASE + 32'h10, 32'h0, "decode_rdata_outside");
    rd_nocs(A_COUNT, 32'h0, "decode_rdata_nocs");

    // Asynchronous reset in the middle of a count.
    wr(A_COUNT, 32'd20);
    wr(A_CTRL, 32'h7);
    idle(5);
    rd_rst(A_COUNT, 32'h0, "rst_async_count");
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_STATUS, 32'h0, "rst_status");
    rd(A_RELOAD, 32'h0, "rst_reload");
    irq_is(1'b0, "rst_irq");
    idle(10);
    rd(A_COUNT, 32'h0, "rst_stays_idle");

    idle(1);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
